// File: rtl/snap_mem_ctrl.sv
// Entry storage and arbitration stage behind the snapshot register block:
// DEPTH x F_WIDTH register array with per-entry valid bits, SW/HW ports and init sweep.
module snap_mem_ctrl #(
  parameter int F_WIDTH    = 36,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] sw_mem_addr,
  input  logic                  sw_mem_rd_en,
  input  logic                  sw_mem_wr_en,
  input  logic [F_WIDTH-1:0]    sw_mem_wr_data,
  output logic [F_WIDTH-1:0]    sw_mem_rd_data,
  output logic                  entry_vld,
  input  logic                  entry_vld_nxt,
  output logic                  sw_wr_drop,
  input  logic [ADDR_WIDTH-1:0] hw_mem_addr,
  input  logic                  hw_mem_rd_en,
  input  logic                  hw_mem_wr_en,
  input  logic [F_WIDTH-1:0]    hw_mem_wr_data,
  output logic [F_WIDTH-1:0]    hw_mem_rd_data,
  output logic                  hw_mem_rd_vld,
  input  logic                  init_req,
  output logic                  init_busy
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [F_WIDTH-1:0]      sw_rd_data_q, sw_rd_data_d;
  logic [F_WIDTH-1:0]      hw_rd_data_q, hw_rd_data_d;
  logic                    hw_rd_vld_q, hw_rd_vld_d;
  logic                    sw_wr_drop_q, sw_wr_drop_d;
  logic                    init_busy_q, init_busy_d;

  logic [F_WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH-1:0]        vld_q;

  logic                    in_run;
  logic                    sw_in_range;
  logic                    hw_in_range;
  logic                    addr_clash;

  // Port A carries either the sweep clear or the software write; port B the hardware write.
  logic                    wa_en;
  logic [ADDR_WIDTH-1:0]   wa_addr;
  logic [F_WIDTH-1:0]      wa_data;
  logic                    wa_vld;
  logic                    wb_en;
  logic [ADDR_WIDTH-1:0]   wb_addr;
  logic [F_WIDTH-1:0]      wb_data;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  assign in_run      = (state_q == ST_RUN);
  assign sw_in_range = in_range(sw_mem_addr);
  assign hw_in_range = in_range(hw_mem_addr);
  assign addr_clash  = sw_mem_wr_en && hw_mem_wr_en && (sw_mem_addr == hw_mem_addr);

  assign entry_vld      = in_run && sw_in_range && vld_q[sw_mem_addr];
  assign sw_mem_rd_data = sw_rd_data_q;
  assign hw_mem_rd_data = hw_rd_data_q;
  assign hw_mem_rd_vld  = hw_rd_vld_q;
  assign sw_wr_drop     = sw_wr_drop_q;
  assign init_busy      = init_busy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    unique case (state_q)
      ST_INIT: begin
        if (int'(cnt_q) == DEPTH - 1) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_busy_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    wa_en   = 1'b0;
    wa_addr = sw_mem_addr;
    wa_data = sw_mem_wr_data;
    wa_vld  = entry_vld_nxt;
    wb_en   = 1'b0;
    wb_addr = hw_mem_addr;
    wb_data = hw_mem_wr_data;
    if (!in_run) begin
      wa_en   = 1'b1;
      wa_addr = cnt_q;
      wa_data = '0;
      wa_vld  = 1'b0;
    end else begin
      wa_en = sw_mem_wr_en && sw_in_range && !addr_clash;
      wb_en = hw_mem_wr_en && hw_in_range;
    end
  end

  // Reads sample the array before this edge's writes, giving read-before-write.
  always_comb begin
    sw_rd_data_d = sw_rd_data_q;
    hw_rd_data_d = hw_rd_data_q;
    hw_rd_vld_d  = hw_mem_rd_en;
    sw_wr_drop_d = sw_mem_wr_en && (!in_run || addr_clash);
    if (sw_mem_rd_en) begin
      sw_rd_data_d = (in_run && sw_in_range) ? mem_q[sw_mem_addr] : '0;
    end
    if (hw_mem_rd_en) begin
      hw_rd_data_d = (in_run && hw_in_range && vld_q[hw_mem_addr]) ? mem_q[hw_mem_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      init_busy_q  <= 1'b1;
      sw_rd_data_q <= '0;
      hw_rd_data_q <= '0;
      hw_rd_vld_q  <= 1'b0;
      sw_wr_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_busy_q  <= init_busy_d;
      sw_rd_data_q <= sw_rd_data_d;
      hw_rd_data_q <= hw_rd_data_d;
      hw_rd_vld_q  <= hw_rd_vld_d;
      sw_wr_drop_q <= sw_wr_drop_d;
    end
  end

  // Storage is not reset; the sweep that always follows reset clears it.
  always_ff @(posedge clk) begin
    if (wa_en) begin
      mem_q[wa_addr] <= wa_data;
      vld_q[wa_addr] <= wa_vld;
    end
    if (wb_en) begin
      mem_q[wb_addr] <= wb_data;
      vld_q[wb_addr] <= 1'b1;
    end
  end

endmodule
